// File: rtl/multicycle_control_g7_pkg.sv
// Shared opcode, FSM state and ALUOp constants for the multi-cycle control unit.
// Extends the single-cycle riscv_defines_g7 set with state codes and a legality helper.
package multicycle_control_g7_pkg;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE_ADDI = 7'b0010011;
  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] B_TYPE      = 7'b1100011;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == R_TYPE) || (op == I_TYPE_ADDI) ||
           (op == I_TYPE_LOAD) || (op == S_TYPE) ||
           (op == B_TYPE);
  endfunction

endpackage

// File: rtl/multicycle_control_g7_timer.sv
// mem_wait_timer_g7: counts consecutive memory-wait cycles.
// Ports: clk, reset, en (waiting state), ready (mem_ready), timeout (trap request).
module mem_wait_timer_g7 #(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic ready,
  output logic timeout
);

  // timeout fires on the cycle that would bring the count to all-ones,
  // i.e. the (2**W-1)-th consecutive wait; ready that cycle still wins.
  localparam logic [TIMEOUT_W-1:0] LAST =
    TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (!en || ready)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  assign timeout = en && !ready && (count == LAST);

endmodule

// File: rtl/multicycle_control_g7.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with memory timeout and illegal-op traps.
// Ports: clk, reset, opcode, zero, mem_ready -> datapath enables, ALUOp, state, instr_done,
//        trap, trap_cause; optional retired counter when RETIRE_CNT_EN is defined.
module multicycle_control_g7
  import multicycle_control_g7_pkg::*;
#(
  parameter int OPCODE_W  = 7,
  parameter int ALUOP_W   = 2,
  parameter int TIMEOUT_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Branch,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [2:0]          state,
  output logic                instr_done,
  output logic                trap,
  output logic                trap_cause
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]    retired
`endif
);

  logic [2:0]          state_q;
  logic [2:0]          nxt;
  logic                nxt_cause;
  logic                cause_q;
  logic [OPCODE_W-1:0] op_q;
  logic                timeout;
  logic                waiting;
  logic [1:0]          alu_op;
  logic                op_r, op_addi, op_ld, op_st, op_br;

  assign op_r    = (op_q == R_TYPE);
  assign op_addi = (op_q == I_TYPE_ADDI);
  assign op_ld   = (op_q == I_TYPE_LOAD);
  assign op_st   = (op_q == S_TYPE);
  assign op_br   = (op_q == B_TYPE);

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);

  mem_wait_timer_g7 #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (waiting),
    .ready  (mem_ready),
    .timeout(timeout)
  );

  always_comb begin
    nxt       = state_q;
    nxt_cause = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          nxt = S_DECODE;
        end else if (timeout) begin
          nxt       = S_TRAP;
          nxt_cause = 1'b1;
        end
      end
      S_DECODE: nxt = is_legal(opcode) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        unique case (1'b1)
          op_r, op_addi: nxt = S_WB;
          op_ld, op_st:  nxt = S_MEM;
          op_br:         nxt = S_FETCH;
          default:       nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          nxt = op_ld ? S_WB : S_FETCH;
        end else if (timeout) begin
          nxt       = S_TRAP;
          nxt_cause = 1'b1;
        end
      end
      S_WB:    nxt = S_FETCH;
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= nxt;
      if (state_q == S_DECODE)
        op_q <= opcode;
      if ((nxt == S_TRAP) && (state_q != S_TRAP))
        cause_q <= nxt_cause;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrc  = 1'b1;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      S_EXEC: begin
        unique case (1'b1)
          op_r: alu_op = ALUOP_FUNCT;
          op_addi, op_ld, op_st: ALUSrc = 1'b1;
          op_br: begin
            alu_op     = ALUOP_SUB;
            Branch     = 1'b1;
            PCWrite    = zero;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ALUSrc     = 1'b1;
        MemRead    = op_ld;
        MemWrite   = op_st;
        instr_done = op_st && mem_ready;
      end
      S_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = op_ld;
        instr_done = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
    // Asynchronous reset kills every enable at once, not at the next edge.
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrc     = 1'b0;
      MemtoReg   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Branch     = 1'b0;
      alu_op     = ALUOP_ADD;
      instr_done = 1'b0;
      trap       = 1'b0;
    end
  end

  assign ALUOp      = ALUOP_W'(alu_op);
  assign state      = state_q;
  assign trap_cause = trap && cause_q;

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retired <= '0;
    else if (instr_done)
      retired <= retired + 1'b1;
  end
`endif

endmodule
